wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage result (Pipe) and a
//  long-latency unit result (Long: multi-cycle FPU mul/div). Pipe has priority; Long results wait in a
//  DEPTH-entry FIFO. If the oldest Long result waits MAX_WAIT Pipe-won cycles, a one-cycle pipeline
//  stall is forced so it can drain. Sits between the WB stage and the register file write port.
// PARAMETERS
//  DATA_W    32  write data width
//  ADDR_W    6   register address width (int + FP file)
//  DEPTH     2   Long result FIFO entries (power of 2, >=2)
//  MAX_WAIT  4   Pipe-won cycles a non-empty FIFO tolerates before forcing a stall (>=1)
// PORTS
//  clk        in   1       clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  PipeWE     in   1       WB stage write request this cycle
//  PipeWAddr  in   ADDR_W  WB stage destination
//  PipeWData  in   DATA_W  WB stage data
//  LongValid  in   1       Long result offered
//  LongReady  out  1       FIFO can accept; transfer when LongValid & LongReady
//  LongWAddr  in   ADDR_W  Long destination
//  LongWData  in   DATA_W  Long data
//  PipeStall  out  1       WB stage must hold its inputs this cycle (not consumed)
//  RegWBWE    out  1       register file write enable (registered)
//  RegWBAddr  out  ADDR_W  register file write address (registered)
//  RegWBData  out  DATA_W  register file write data (registered)
// BEHAVIOUR
//  - Reset: FIFO empty (ptrs, count = 0, all entry valid bits 0), wait_cnt = 0, state IDLE,
//    RegWBWE = 0, RegWBAddr = 0, RegWBData = 0, PipeStall = 0, LongReady = 1 next cycle.
//  - States: IDLE (FIFO empty), PENDING (FIFO non-empty), FORCE (stall cycle). PipeStall = (state==FORCE).
//  - Per-cycle grant, winner registered onto RegWB* next edge (latency 1 cycle):
//    FORCE: FIFO head written and popped, Pipe inputs ignored; -> PENDING if entries remain else IDLE;
//      wait_cnt = 0.
//    else PipeWE = 1: Pipe written; if FIFO non-empty, wait_cnt + 1.
//    else FIFO non-empty: head written and popped; wait_cnt = 0.
//    else RegWBWE = 0 (addr/data hold previous value).
//  - PENDING -> FORCE when PipeWE = 1 and wait_cnt == MAX_WAIT-1 (i.e. the MAX_WAIT-th lost cycle).
//  - LongReady = (count < DEPTH), from registered count; no push when full even if popping same cycle.
//    Push and pop in same cycle allowed when not full; count unchanged.
//  - Popped entry with valid bit 0 (squashed): popped silently, RegWBWE = 0 that cycle, wait_cnt = 0.
//  - WAW squash: Pipe write granted with PipeWAddr equal to the address of any valid FIFO entry clears
//    that entry's valid bit (younger Pipe write wins). An entry pushed in the same cycle is not squashed.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH+1); wait_cnt width clog2(MAX_WAIT+1), saturates.
//  - Reset mid-operation discards all buffered results and any pending FORCE.
// STRUCTURE
//  - Package wb_arb_pkg: state encodings (IDLE, PENDING, FORCE), default widths.
//  - Sub-module wb_result_fifo: DEPTH x {valid, addr, data} with push/pop, count, full/empty,
//    per-entry squash-by-address port. Arbiter FSM, wait counter, output registers stay in top.
// TESTING
//  1 Reset: assert reset 2 cycles mid-traffic -> next cycle RegWBWE=0, Addr=0, Data=0, PipeStall=0,
//    LongReady=1, FIFO empty.
//  2 Idle port: PipeWE=0, push Long (addr 5, 0xDEADBEEF) -> RegWBWE=1, Addr=5, Data=0xDEADBEEF two
//    edges after push; back to IDLE.
//  3 Starvation: Long (addr 7) buffered, PipeWE=1 every cycle -> after 4 Pipe writes PipeStall=1 for
//    exactly 1 cycle, addr 7 written next edge, Pipe data held that cycle is written the cycle after.
//  4 Full: PipeWE=1 continuously, push 2 Long results -> LongReady=0, third LongValid not accepted
//    until a pop; order of Long writes = push order.
//  5 WAW: FIFO holds addr 9 = 0x1; Pipe writes addr 9 = 0x2 -> addr 9 never rewritten with 0x1;
//    squashed pop shows RegWBWE=0.
//  6 Simultaneous: FIFO 1 entry, PipeWE=0 and LongValid=1 same cycle -> head written, new entry
//    pushed, count stays 1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the write-back port arbiter.
// Defines the arbiter state encoding and the parameter defaults that the
// interface, the result FIFO and the top all pick up.
package wb_arb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 6;
    localparam int DEPTH_DEF    = 2;
    localparam int MAX_WAIT_DEF = 4;

    // IDLE: no Long result buffered; PENDING: buffered results waiting;
    // FORCE: the WB stage is stalled this cycle so the FIFO head can drain.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FORCE   = 2'd2
    } arbState_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of WB-stage, long-latency-unit and register-file write-port signals.
// Pure wiring, no latency of its own.
// Long side uses valid/ready; Pipe side is held back by PipeStall.
interface wb_port_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              PipeWE;
    logic [ADDR_W-1:0] PipeWAddr;
    logic [DATA_W-1:0] PipeWData;
    logic              LongValid;
    logic              LongReady;
    logic [ADDR_W-1:0] LongWAddr;
    logic [DATA_W-1:0] LongWData;
    logic              PipeStall;
    logic              RegWBWE;
    logic [ADDR_W-1:0] RegWBAddr;
    logic [DATA_W-1:0] RegWBData;

    // Producer side: WB stage, long unit, and the register file observer.
    modport master (
        output PipeWE, PipeWAddr, PipeWData,
        output LongValid, LongWAddr, LongWData,
        input  LongReady, PipeStall,
        input  RegWBWE, RegWBAddr, RegWBData
    );

    // Arbiter side.
    modport slave (
        input  PipeWE, PipeWAddr, PipeWData,
        input  LongValid, LongWAddr, LongWData,
        output LongReady, PipeStall,
        output RegWBWE, RegWBAddr, RegWBData
    );
endinterface

// File: rtl/wb_result_fifo.sv
// DEPTH-entry FIFO of {valid, addr, data} long-unit results with squash-by-address.
// Head is visible combinationally; push/pop/squash take effect at the next edge.
// Push is dropped when full, pop is dropped when empty; caller gates with full/empty.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          pushAddr,
    input  logic [DATA_W-1:0]          pushData,
    input  logic                       pop,
    input  logic                       squashEn,
    input  logic [ADDR_W-1:0]          squashAddr,
    output logic                       headValid,
    output logic [ADDR_W-1:0]          headAddr,
    output logic [DATA_W-1:0]          headData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  entryValid;
    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              doPush;
    logic              doPop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign headValid = entryValid[rdPtr];
    assign headAddr  = entryAddr[rdPtr];
    assign headData  = entryData[rdPtr];

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (!doPush && doPop) count <= count - 1'b1;
        end
    end

    // Valid bits: squash first, then pop clears, then push sets, so an entry
    // written this cycle survives a same-cycle squash of its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            entryValid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squashEn && entryValid[i] && entryAddr[i] == squashAddr)
                    entryValid[i] <= 1'b0;
            end
            if (doPop)  entryValid[rdPtr] <= 1'b0;
            if (doPush) entryValid[wrPtr] <= 1'b1;
        end
    end

    // Payload storage needs no reset; the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entryAddr[wrPtr] <= pushAddr;
            entryData[wrPtr] <= pushData;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage (priority) and buffered long-unit results.
// One cycle from grant to registered RegWB* outputs.
// Long side is throttled by LongReady (FIFO space); Pipe is stalled one cycle after MAX_WAIT lost cycles.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    arbState_t         state;
    arbState_t         stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic              stallQ;
    logic              wbWeQ;
    logic [ADDR_W-1:0] wbAddrQ;
    logic [DATA_W-1:0] wbDataQ;

    logic              headValid;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    logic              pushEn;
    logic              popHead;
    logic              grantPipe;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              nextNonEmpty;

    assign pushEn        = bus.LongValid && !full;
    assign bus.LongReady = !full;
    assign bus.PipeStall = stallQ;
    assign bus.RegWBWE   = wbWeQ;
    assign bus.RegWBAddr = wbAddrQ;
    assign bus.RegWBData = wbDataQ;

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (pushEn),
        .pushAddr   (bus.LongWAddr),
        .pushData   (bus.LongWData),
        .pop        (popHead),
        .squashEn   (grantPipe),
        .squashAddr (bus.PipeWAddr),
        .headValid  (headValid),
        .headAddr   (headAddr),
        .headData   (headData),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Grant: forced drain beats Pipe, Pipe beats a waiting FIFO head.
    // A squashed head is popped without raising the write enable.
    always_comb begin
        popHead   = 1'b0;
        grantPipe = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = bus.PipeWAddr;
        wrData    = bus.PipeWData;
        if (state == FORCE) begin
            popHead = 1'b1;
            wrEn    = headValid;
            wrAddr  = headAddr;
            wrData  = headData;
        end else if (bus.PipeWE) begin
            grantPipe = 1'b1;
            wrEn      = 1'b1;
        end else if (!empty) begin
            popHead = 1'b1;
            wrEn    = headValid;
            wrAddr  = headAddr;
            wrData  = headData;
        end
    end

    // Next state: force a stall on the MAX_WAIT-th lost cycle, else follow FIFO occupancy.
    always_comb begin
        nextNonEmpty = pushEn || (count > (popHead ? CNT_ONE : '0));
        stateNext    = IDLE;
        if (state != FORCE && grantPipe && !empty && waitCnt == WAIT_LAST)
            stateNext = FORCE;
        else if (nextNonEmpty)
            stateNext = PENDING;
    end

    // Arbiter FSM, starvation counter and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stallQ  <= 1'b0;
            waitCnt <= '0;
            wbWeQ   <= 1'b0;
            wbAddrQ <= '0;
            wbDataQ <= '0;
        end else begin
            state  <= stateNext;
            stallQ <= (stateNext == FORCE);
            if (popHead)
                waitCnt <= '0;
            else if (grantPipe && !empty && waitCnt != WAIT_SAT)
                waitCnt <= waitCnt + 1'b1;
            wbWeQ <= wrEn;
            if (wrEn) begin
                wbAddrQ <= wrAddr;
                wbDataQ <= wrData;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed checks of the write-back port arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Bench honours PipeStall by re-presenting the same Pipe write.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drivePipe(input logic we, input logic [5:0] a, input logic [31:0] d);
        bus.PipeWE    = we;
        bus.PipeWAddr = a;
        bus.PipeWData = d;
    endtask

    task automatic driveLong(input logic v, input logic [5:0] a, input logic [31:0] d);
        bus.LongValid = v;
        bus.LongWAddr = a;
        bus.LongWData = d;
    endtask

    task automatic checkWrite(input string tag, input logic [5:0] a, input logic [31:0] d);
        checkVal({tag, "_we"},   32'(bus.RegWBWE),   32'd1);
        checkVal({tag, "_addr"}, 32'(bus.RegWBAddr), 32'(a));
        checkVal({tag, "_data"}, bus.RegWBData,      d);
    endtask

    initial begin
        reset = 1'b1;
        drivePipe(1'b0, 6'h0, 32'h0);
        driveLong(1'b0, 6'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkVal("por_we",    32'(bus.RegWBWE),   32'd0);
        checkVal("por_ready", 32'(bus.LongReady), 32'd1);

        // Reset mid-traffic with a FORCE about to happen and a result buffered.
        drivePipe(1'b1, 6'h01, 32'h11);
        driveLong(1'b1, 6'h03, 32'h33);
        tick();
        driveLong(1'b0, 6'h00, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        checkVal("rst_pre_stall", 32'(bus.PipeStall), 32'd1);
        reset = 1'b1;
        driveLong(1'b1, 6'h04, 32'h44);
        tick();
        tick();
        checkVal("rst_we",    32'(bus.RegWBWE),     32'd0);
        checkVal("rst_addr",  32'(bus.RegWBAddr),   32'd0);
        checkVal("rst_data",  bus.RegWBData,        32'd0);
        checkVal("rst_stall", 32'(bus.PipeStall),   32'd0);
        checkVal("rst_ready", 32'(bus.LongReady),   32'd1);
        checkVal("rst_count", 32'(u_dut.u_fifo.count), 32'd0);
        reset = 1'b0;
        drivePipe(1'b0, 6'h0, 32'h0);
        driveLong(1'b0, 6'h0, 32'h0);
        tick();
        checkVal("rst_after_we",    32'(bus.RegWBWE),   32'd0);
        checkVal("rst_after_stall", 32'(bus.PipeStall), 32'd0);

        // Idle port: a Long result goes straight through the FIFO.
        driveLong(1'b1, 6'h05, 32'hDEADBEEF);
        tick();
        checkVal("idle_push_we",    32'(bus.RegWBWE),   32'd0);
        checkVal("idle_push_ready", 32'(bus.LongReady), 32'd1);
        driveLong(1'b0, 6'h00, 32'h0);
        tick();
        checkWrite("idle_long", 6'h05, 32'hDEADBEEF);
        checkVal("idle_state", 32'(u_dut.state), 32'(IDLE));
        tick();
        checkVal("idle_hold_we",   32'(bus.RegWBWE),   32'd0);
        checkVal("idle_hold_addr", 32'(bus.RegWBAddr), 32'd5);

        // Starvation: four lost cycles then exactly one forced stall.
        drivePipe(1'b1, 6'h01, 32'h101);
        driveLong(1'b1, 6'h07, 32'h77);
        tick();
        checkWrite("starve_p1", 6'h01, 32'h101);
        driveLong(1'b0, 6'h00, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            drivePipe(1'b1, 6'(i), 32'h100 + 32'(i));
            tick();
            checkVal("starve_nostall", 32'(bus.PipeStall), 32'd0);
        end
        drivePipe(1'b1, 6'h05, 32'h105);
        tick();
        checkWrite("starve_p5", 6'h05, 32'h105);
        checkVal("starve_stall", 32'(bus.PipeStall), 32'd1);
        drivePipe(1'b1, 6'h06, 32'h106);
        tick();
        checkWrite("starve_long", 6'h07, 32'h77);
        checkVal("starve_stall_end", 32'(bus.PipeStall), 32'd0);
        tick();
        checkWrite("starve_held", 6'h06, 32'h106);

        // Full FIFO: third Long waits for a pop; drain order is push order.
        drivePipe(1'b1, 6'h10, 32'h1010);
        driveLong(1'b1, 6'h20, 32'hA1);
        tick();
        checkVal("full_ready1", 32'(bus.LongReady), 32'd1);
        drivePipe(1'b1, 6'h11, 32'h1011);
        driveLong(1'b1, 6'h21, 32'hA2);
        tick();
        checkVal("full_ready2", 32'(bus.LongReady), 32'd0);
        drivePipe(1'b1, 6'h12, 32'h1012);
        driveLong(1'b1, 6'h22, 32'hA3);
        tick();
        checkVal("full_ready3", 32'(bus.LongReady), 32'd0);
        checkVal("full_count",  32'(u_dut.u_fifo.count), 32'd2);
        drivePipe(1'b1, 6'h13, 32'h1013);
        tick();
        drivePipe(1'b1, 6'h14, 32'h1014);
        tick();
        checkVal("full_stall",  32'(bus.PipeStall), 32'd1);
        checkVal("full_ready4", 32'(bus.LongReady), 32'd0);
        drivePipe(1'b1, 6'h15, 32'h1015);
        tick();
        checkWrite("full_long1", 6'h20, 32'hA1);
        checkVal("full_ready5", 32'(bus.LongReady), 32'd1);
        tick();
        checkWrite("full_pipe_held", 6'h15, 32'h1015);
        drivePipe(1'b0, 6'h00, 32'h0);
        driveLong(1'b0, 6'h00, 32'h0);
        tick();
        checkWrite("full_long2", 6'h21, 32'hA2);
        tick();
        checkWrite("full_long3", 6'h22, 32'hA3);
        tick();
        checkVal("full_drained_we", 32'(bus.RegWBWE), 32'd0);

        // WAW: younger Pipe write to addr 9 squashes the buffered one.
        drivePipe(1'b1, 6'h30, 32'h30);
        driveLong(1'b1, 6'h09, 32'h1);
        tick();
        driveLong(1'b0, 6'h00, 32'h0);
        drivePipe(1'b1, 6'h09, 32'h2);
        tick();
        checkWrite("waw_pipe", 6'h09, 32'h2);
        drivePipe(1'b0, 6'h00, 32'h0);
        tick();
        checkVal("waw_squash_we",   32'(bus.RegWBWE),       32'd0);
        checkVal("waw_squash_data", bus.RegWBData,          32'h2);
        checkVal("waw_count",       32'(u_dut.u_fifo.count), 32'd0);

        // Same-cycle push is not squashed by a matching Pipe write.
        drivePipe(1'b1, 6'h0A, 32'hB);
        driveLong(1'b1, 6'h0A, 32'hC);
        tick();
        drivePipe(1'b0, 6'h00, 32'h0);
        driveLong(1'b0, 6'h00, 32'h0);
        tick();
        checkWrite("waw_samecyc", 6'h0A, 32'hC);

        // Simultaneous push and pop with one entry buffered.
        drivePipe(1'b1, 6'h2A, 32'h2A);
        driveLong(1'b1, 6'h11, 32'h51);
        tick();
        drivePipe(1'b0, 6'h00, 32'h0);
        driveLong(1'b1, 6'h12, 32'h52);
        tick();
        checkWrite("sim_head", 6'h11, 32'h51);
        checkVal("sim_count", 32'(u_dut.u_fifo.count), 32'd1);
        checkVal("sim_ready", 32'(bus.LongReady),      32'd1);
        driveLong(1'b0, 6'h00, 32'h0);
        tick();
        checkWrite("sim_next", 6'h12, 32'h52);
        checkVal("sim_empty", 32'(u_dut.u_fifo.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
